// File: rtl/cnn_layer_accel_pkg.sv
// cnn_layer_accel_pkg: definitions shared by the weight loader and the weight table.
package cnn_layer_accel_pkg;
   localparam int KERNEL_3x3_COUNT_FULL_MINUS_1 = 8;
   localparam int WEIGHT_WIDTH                  = 16;
   localparam int WHT_TBL_MAX_KERNELS           = 64;
   typedef enum logic [2:0] {IDLE, ACCEPT, LOAD, FLUSH, FINISH} wl_state_e;
endpackage

// File: rtl/cnn_layer_accel_weight_loader.sv
// cnn_layer_accel_weight_loader: streams 3x3 kernel weights of one layer job into the weight table.
//   job_*               : job request/handshake (start, kernel count, busy, done, error)
//   wht_in_*            : ready/valid weight stream, kernel-major, weight index 0..8
//   config_mode, job_accept, kernel_config_valid, num_kernels, wht_config_* : weight table config port
module cnn_layer_accel_weight_loader
   import cnn_layer_accel_pkg::*;
#(
   parameter int C_WEIGHT_WIDTH = WEIGHT_WIDTH,
   parameter int C_KERNEL_SIZE  = KERNEL_3x3_COUNT_FULL_MINUS_1 + 1,
   parameter int C_MAX_KERNELS  = WHT_TBL_MAX_KERNELS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      job_start,
   input  logic [15:0]               job_num_kernels,
   output logic                      job_busy,
   output logic                      job_done,
   output logic                      job_err,
   input  logic                      wht_in_valid,
   input  logic [C_WEIGHT_WIDTH-1:0] wht_in_data,
   output logic                      wht_in_ready,
   output logic                      config_mode,
   output logic                      job_accept,
   output logic                      kernel_config_valid,
   output logic [15:0]               num_kernels,
   output logic                      wht_config_wren,
   output logic [C_WEIGHT_WIDTH-1:0] wht_config_data
);
   localparam logic [3:0]  W_LAST = 4'(C_KERNEL_SIZE - 1);
   localparam logic [15:0] K_MAX  = 16'(C_MAX_KERNELS - 1);
   wl_state_e                 state_q, state_d;
   logic [15:0]               nk_q, nk_d;
   logic [3:0]                widx_q, widx_d;
   logic [5:0]                kidx_q, kidx_d;
   logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                      ready_q, ready_d, cfg_q, cfg_d, acc_q, acc_d, kcv_q, kcv_d;
   logic                      wren_q, wren_d;
   logic [C_WEIGHT_WIDTH-1:0] wdata_q, wdata_d;
   logic                      take, wrap, last;
   always_comb begin
      state_d = state_q;
      nk_d    = nk_q;
      widx_d  = widx_q;
      kidx_d  = kidx_q;
      err_d   = 1'b0;
      take    = wht_in_valid && ready_q;
      wrap    = widx_q == W_LAST;
      last    = take && wrap && kidx_q == nk_q[5:0];
      case (state_q)
         IDLE: begin
            if (job_start && job_num_kernels > K_MAX) err_d = 1'b1;
            else if (job_start) begin
               nk_d    = job_num_kernels;
               widx_d  = '0;
               kidx_d  = '0;
               state_d = ACCEPT;
            end
         end
         ACCEPT: state_d = LOAD;
         LOAD: begin
            if (take) begin
               widx_d = wrap ? 4'd0 : widx_q + 4'd1;
               kidx_d = wrap ? kidx_q + 6'd1 : kidx_q;
            end
            if (last) state_d = FLUSH;
         end
         FLUSH:   state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d  = state_d != IDLE;
      acc_d   = state_d == ACCEPT || state_d == FINISH;
      kcv_d   = state_d == ACCEPT;
      cfg_d   = state_d == ACCEPT || state_d == LOAD || state_d == FLUSH;
      done_d  = state_d == FINISH;
      // ready is a registered view of LOAD, so it rises one cycle after LOAD is entered
      ready_d = state_q == LOAD && state_d == LOAD;
      wren_d  = take;
      wdata_d = take ? wht_in_data : wdata_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         nk_q    <= '0;
         widx_q  <= '0;
         kidx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         cfg_q   <= 1'b0;
         acc_q   <= 1'b0;
         kcv_q   <= 1'b0;
         wren_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         nk_q    <= nk_d;
         widx_q  <= widx_d;
         kidx_q  <= kidx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         cfg_q   <= cfg_d;
         acc_q   <= acc_d;
         kcv_q   <= kcv_d;
         wren_q  <= wren_d;
         wdata_q <= wdata_d;
      end
   end
   assign job_busy            = busy_q;
   assign job_done            = done_q;
   assign job_err             = err_q;
   assign wht_in_ready        = ready_q;
   assign config_mode         = cfg_q;
   assign job_accept          = acc_q;
   assign kernel_config_valid = kcv_q;
   assign num_kernels         = nk_q;
   assign wht_config_wren     = wren_q;
   assign wht_config_data     = wdata_q;
endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// tb_cnn_layer_accel_weight_loader: directed self-checking bench with a weight table model.
module tb_cnn_layer_accel_weight_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        job_start = 1'b0;
   logic [15:0] job_num_kernels = '0;
   logic        job_busy, job_done, job_err;
   logic        wht_in_valid = 1'b0;
   logic [15:0] wht_in_data = '0;
   logic        wht_in_ready, config_mode, job_accept, kernel_config_valid;
   logic [15:0] num_kernels;
   logic        wht_config_wren;
   logic [15:0] wht_config_data;
   int          cyc = 0;
   int          c0 = 0;
   int          pass_cnt = 0;
   int          total = 0;
   logic [15:0] wlog[$];
   int          acc_log[$];
   int          done_log[$];
   int          err_log[$];
   int          wren_bad = 0;
   bit          prev_take = 1'b0;
   logic [15:0] tbl[1024];
   logic [5:0]  grp = '0;
   logic [3:0]  cnt = '0;

   cnn_layer_accel_weight_loader dut (
      .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_num_kernels(job_num_kernels),
      .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
      .wht_in_valid(wht_in_valid), .wht_in_data(wht_in_data), .wht_in_ready(wht_in_ready),
      .config_mode(config_mode), .job_accept(job_accept), .kernel_config_valid(kernel_config_valid),
      .num_kernels(num_kernels), .wht_config_wren(wht_config_wren), .wht_config_data(wht_config_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // weight table model: writes at {group, count}, group advances when count wraps 8->0
   always @(negedge clk) begin
      if (rst_n && wht_config_wren !== prev_take) wren_bad++;
      prev_take = rst_n && wht_in_valid && wht_in_ready;
      if (wht_config_wren === 1'b1) begin
         wlog.push_back(wht_config_data);
         if (config_mode === 1'b1) begin
            tbl[{grp, cnt}] = wht_config_data;
            if (cnt == 4'd8) begin
               cnt = '0;
               grp = grp + 6'd1;
            end else cnt = cnt + 4'd1;
         end
      end
      if (job_accept === 1'b1) begin
         acc_log.push_back(cyc);
         grp = '0;
         cnt = '0;
      end
      if (job_done === 1'b1) done_log.push_back(cyc);
      if (job_err === 1'b1) err_log.push_back(cyc);
   end

   task automatic clr();
      wlog.delete();
      acc_log.delete();
      done_log.delete();
      err_log.delete();
      wren_bad = 0;
   endtask

   task automatic start_job(input logic [15:0] n);
      job_start = 1'b1;
      job_num_kernels = n;
      c0 = cyc;
      @(posedge clk); #1;
      job_start = 1'b0;
   endtask

   task automatic stream(input int n, input logic [15:0] base, input bit toggle);
      int i = 0;
      int c = 0;
      bit ph = 1'b1;
      while (i < n && c < 400) begin
         wht_in_valid = toggle ? ph : 1'b1;
         wht_in_data = base + 16'(i);
         @(negedge clk);
         if (wht_in_valid && wht_in_ready) i++;
         @(posedge clk); #1;
         ph = !ph;
         c++;
      end
      wht_in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (job_done !== 1'b1 && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({job_busy, job_done, job_err, wht_in_ready, config_mode, job_accept, kernel_config_valid,
           num_kernels, wht_config_wren, wht_config_data} !== 40'd0)
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b rdy=%b cfg=%b acc=%b kcv=%b nk=%h wren=%b data=%h, want all 0",
                  job_busy, job_done, job_err, wht_in_ready, config_mode, job_accept, kernel_config_valid,
                  num_kernels, wht_config_wren, wht_config_data);
      else pass_cnt++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (job_busy !== 1'b0 || wht_in_ready !== 1'b0) $display("FAIL reset_idle: busy=%b rdy=%b want 0 0", job_busy, wht_in_ready);
      else pass_cnt++;
   endtask

   task automatic test_single();
      clr();
      start_job(16'd0);
      total++;
      if (job_busy !== 1'b1 || kernel_config_valid !== 1'b1 || config_mode !== 1'b1)
         $display("FAIL accept_cycle: busy=%b kcv=%b cfg=%b want 1 1 1", job_busy, kernel_config_valid, config_mode);
      else pass_cnt++;
      stream(9, 16'h0001, 1'b0);
      wait_done();
      total++;
      if (wlog.size() != 9) $display("FAIL single_wren_count: got %0d want 9", wlog.size());
      else pass_cnt++;
      for (int i = 0; i < 9 && i < wlog.size(); i++) begin
         total++;
         if (wlog[i] !== 16'(i + 1)) $display("FAIL single_order[%0d]: got %h want %h", i, wlog[i], 16'(i + 1));
         else pass_cnt++;
      end
      total++;
      if (acc_log.size() != 2 || acc_log[0] != c0 + 1 || acc_log[1] != c0 + 13)
         $display("FAIL single_accept_cycles: got n=%0d first=%0d last=%0d want 2 1 13", acc_log.size(),
                  acc_log.size() > 0 ? acc_log[0] - c0 : -1, acc_log.size() > 1 ? acc_log[1] - c0 : -1);
      else pass_cnt++;
      total++;
      if (done_log.size() != 1 || done_log[0] != c0 + 13)
         $display("FAIL single_done_cycle: got n=%0d cyc=%0d want 1 13", done_log.size(),
                  done_log.size() > 0 ? done_log[0] - c0 : -1);
      else pass_cnt++;
      for (int w = 0; w < 9; w++) begin
         total++;
         if (tbl[w] !== 16'(w + 1)) $display("FAIL single_table[%0d]: got %h want %h", w, tbl[w], 16'(w + 1));
         else pass_cnt++;
      end
      total++;
      if (wren_bad != 0 || job_busy !== 1'b0) $display("FAIL single_wren_align: bad=%0d busy=%b want 0 0", wren_bad, job_busy);
      else pass_cnt++;
   endtask

   task automatic test_bubbles();
      clr();
      start_job(16'd2);
      stream(27, 16'h0A00, 1'b1);
      wait_done();
      total++;
      if (wlog.size() != 27) $display("FAIL bubble_wren_count: got %0d want 27", wlog.size());
      else pass_cnt++;
      total++;
      if (wren_bad != 0) $display("FAIL bubble_wren_align: got %0d misaligned wrens want 0", wren_bad);
      else pass_cnt++;
      for (int k = 0; k < 3; k++)
         for (int w = 0; w < 9; w++) begin
            total++;
            if (tbl[k * 16 + w] !== 16'(16'h0A00 + k * 9 + w))
               $display("FAIL bubble_table[%0d][%0d]: got %h want %h", k, w, tbl[k * 16 + w], 16'(16'h0A00 + k * 9 + w));
            else pass_cnt++;
         end
      total++;
      if (grp !== 6'd0 || cnt !== 4'd0) $display("FAIL bubble_group_reset: got grp=%0d cnt=%0d want 0 0", grp, cnt);
      else pass_cnt++;
      total++;
      if (num_kernels !== 16'd2) $display("FAIL bubble_num_kernels: got %0d want 2", num_kernels);
      else pass_cnt++;
   endtask

   task automatic test_err();
      clr();
      start_job(16'd64);
      total++;
      if (job_err !== 1'b1 || job_busy !== 1'b0 || config_mode !== 1'b0 || wht_in_ready !== 1'b0)
         $display("FAIL err_pulse: err=%b busy=%b cfg=%b rdy=%b want 1 0 0 0", job_err, job_busy, config_mode, wht_in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      total++;
      if (job_err !== 1'b0 || job_busy !== 1'b0 || job_accept !== 1'b0)
         $display("FAIL err_single: err=%b busy=%b acc=%b want 0 0 0", job_err, job_busy, job_accept);
      else pass_cnt++;
      total++;
      if (num_kernels !== 16'd2) $display("FAIL err_num_kernels: got %0d want 2", num_kernels);
      else pass_cnt++;
   endtask

   task automatic test_ignore();
      clr();
      start_job(16'd1);
      fork
         stream(18, 16'h0300, 1'b0);
         begin
            repeat (6) @(posedge clk);
            #1;
            job_start = 1'b1;
            job_num_kernels = 16'd5;
            @(posedge clk); #1;
            job_start = 1'b0;
         end
      join
      wait_done();
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (num_kernels !== 16'd1) $display("FAIL ignore_num_kernels: got %0d want 1", num_kernels);
      else pass_cnt++;
      total++;
      if (done_log.size() != 1 || err_log.size() != 0)
         $display("FAIL ignore_done_count: got done=%0d err=%0d want 1 0", done_log.size(), err_log.size());
      else pass_cnt++;
      total++;
      if (wlog.size() != 18) $display("FAIL ignore_wren_count: got %0d want 18", wlog.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      clr();
      start_job(16'd1);
      stream(5, 16'h0500, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({job_busy, job_done, job_err, wht_in_ready, config_mode, job_accept, kernel_config_valid,
           num_kernels, wht_config_wren, wht_config_data} !== 40'd0)
         $display("FAIL midreset_outputs: got busy=%b rdy=%b cfg=%b nk=%h wren=%b data=%h want all 0",
                  job_busy, wht_in_ready, config_mode, num_kernels, wht_config_wren, wht_config_data);
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (done_log.size() != 0 || job_busy !== 1'b0) $display("FAIL midreset_no_done: got done=%0d busy=%b want 0 0", done_log.size(), job_busy);
      else pass_cnt++;
      clr();
      start_job(16'd0);
      stream(9, 16'h0600, 1'b0);
      wait_done();
      total++;
      if (wlog.size() != 9 || done_log.size() != 1)
         $display("FAIL midreset_rerun: got wrens=%0d done=%0d want 9 1", wlog.size(), done_log.size());
      else pass_cnt++;
      for (int w = 0; w < 9; w++) begin
         total++;
         if (tbl[w] !== 16'(16'h0600 + w)) $display("FAIL midreset_table[%0d]: got %h want %h", w, tbl[w], 16'(16'h0600 + w));
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int c_a;
      clr();
      start_job(16'd0);
      c_a = c0;
      stream(9, 16'h00B0, 1'b0);
      wait_done();
      start_job(16'd0);
      stream(9, 16'h00C0, 1'b0);
      wait_done();
      total++;
      if (acc_log.size() != 4 || acc_log[2] != acc_log[1] + 2 || acc_log[1] != c_a + 13)
         $display("FAIL b2b_accept: got n=%0d gap=%0d want 4 2", acc_log.size(),
                  acc_log.size() > 2 ? acc_log[2] - acc_log[1] : -1);
      else pass_cnt++;
      total++;
      if (done_log.size() != 2 || done_log[1] != c0 + 13)
         $display("FAIL b2b_done: got n=%0d cyc=%0d want 2 13", done_log.size(),
                  done_log.size() > 1 ? done_log[1] - c0 : -1);
      else pass_cnt++;
      total++;
      if (wlog.size() != 18) $display("FAIL b2b_wren_count: got %0d want 18", wlog.size());
      else pass_cnt++;
      for (int w = 0; w < 9; w++) begin
         total++;
         if (tbl[w] !== 16'(16'h00C0 + w)) $display("FAIL b2b_table[%0d]: got %h want %h", w, tbl[w], 16'(16'h00C0 + w));
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_bubbles();
      test_err();
      test_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
